// File: rtl/if_fetch_buffer_pkg.sv
// Shared fetch-buffer types and constants.
// Packet layout on the fetch data bus: {pc, inst}.
package if_fetch_buffer_pkg;

   localparam int FETCH_BUS_W = 64;
   localparam int PC_HI       = 63;
   localparam int PC_LO       = 32;
   localparam int INST_HI     = 31;
   localparam int INST_LO     = 0;

   localparam logic [31:0] RESET_PC = 32'h1C00_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_pkt_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic DEPTH x W synchronous FIFO with clear and occupancy.
// Occupancy is a counter; pointers wrap naturally at log2(DEPTH).
module fetch_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 32,
   parameter int CNT_W = 3
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             push_i,
   input  logic [W-1:0]     din_i,
   input  logic             pop_i,
   output logic [W-1:0]     dout_o,
   output logic [CNT_W-1:0] occ_o
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]     mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, rptr_q;
   logic [CNT_W-1:0] occ_q;
   logic             do_push, do_pop;

   assign do_pop  = pop_i && (occ_q != '0);
   assign do_push = push_i && ((occ_q != CNT_W'(DEPTH)) || do_pop);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
         occ_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (clr_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         occ_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wptr_q] <= din_i;
            wptr_q        <= wptr_q + AW'(1);
         end
         if (do_pop) rptr_q <= rptr_q + AW'(1);
         occ_q <= occ_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   assign dout_o = mem_q[rptr_q];
   assign occ_o  = occ_q;

endmodule

// File: rtl/if_fetch_buffer.sv
// Fetch buffer: issues imem requests, tags returns with their PC,
// queues {pc, inst} for ID and cancels in-flight fetches on redirect.
module if_fetch_buffer
   import if_fetch_buffer_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [31:0]            pc,
   input  logic                   pc_valid,
   output logic                   fire,
   output logic                   addr_trans_ready,
   input  logic                   redirect,
   output logic                   inst_req,
   output logic [31:0]            inst_addr,
   input  logic                   inst_addr_ok,
   input  logic                   inst_data_ok,
   input  logic [31:0]            inst_rdata,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [FETCH_BUS_W-1:0] data_bus
);

   localparam int SW = CNT_W + 2;

   logic [CNT_W-1:0] outst_q, outst_d;
   logic [CNT_W-1:0] cancel_q, cancel_d;
   logic [CNT_W-1:0] occ, tag_occ;
   logic [SW-1:0]    load;
   logic             room, drop, take, pop;
   logic [31:0]      tag;
   fetch_pkt_t       pkt_in, head;

   // cancelled fetches still occupy memory-side capacity
   assign load = SW'(occ) + SW'(outst_q) + SW'(cancel_q);
   assign room = reset && (load < SW'(DEPTH));

   assign addr_trans_ready = room && !redirect;
   assign inst_req         = pc_valid && addr_trans_ready;
   assign inst_addr        = pc;
   assign fire             = inst_req && inst_addr_ok;

   assign drop = inst_data_ok && (cancel_q != '0);
   assign take = inst_data_ok && (cancel_q == '0)
              && (outst_q != '0) && !redirect;
   assign pop  = out_valid && out_ready;

   assign pkt_in.pc   = tag;
   assign pkt_in.inst = inst_rdata;

   always_comb begin
      outst_d  = outst_q;
      cancel_d = cancel_q;
      if (redirect) begin
         outst_d  = '0;
         // a return arriving now consumes one of the pending slots
         cancel_d = cancel_q + outst_q
                  - CNT_W'(inst_data_ok && ((cancel_q != '0) || (outst_q != '0)));
      end else begin
         if (drop) cancel_d = cancel_q - CNT_W'(1);
         outst_d = outst_q + CNT_W'(fire) - CNT_W'(take);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         outst_q  <= '0;
         cancel_q <= '0;
      end else begin
         outst_q  <= outst_d;
         cancel_q <= cancel_d;
      end
   end

   fetch_fifo #(.DEPTH(DEPTH), .W(32), .CNT_W(CNT_W)) u_tag_q (
      .clk_i  (clk),
      .rst_ni (reset),
      .clr_i  (redirect),
      .push_i (fire),
      .din_i  (pc),
      .pop_i  (take),
      .dout_o (tag),
      .occ_o  (tag_occ)
   );

   fetch_fifo #(.DEPTH(DEPTH), .W(FETCH_BUS_W), .CNT_W(CNT_W)) u_data_q (
      .clk_i  (clk),
      .rst_ni (reset),
      .clr_i  (redirect),
      .push_i (take),
      .din_i  (pkt_in),
      .pop_i  (pop),
      .dout_o (head),
      .occ_o  (occ)
   );

   assign out_valid                 = (occ != '0);
   assign data_bus[PC_HI:PC_LO]     = head.pc;
   assign data_bus[INST_HI:INST_LO] = head.inst;

   a_no_spurious_ret: assert property (@(posedge clk) disable iff (!reset)
      inst_data_ok |-> ((outst_q != '0) || (cancel_q != '0)));

   a_cap: assert property (@(posedge clk) disable iff (!reset)
      (SW'(outst_q) + SW'(cancel_q)) <= SW'(DEPTH));

   a_tag_sync: assert property (@(posedge clk) disable iff (!reset)
      tag_occ == outst_q);

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Directed bench for if_fetch_buffer.
// Inputs change 1 time unit after the rising edge; outputs sampled mid-cycle.
module tb_if_fetch_buffer;

   logic        clk;
   logic        reset;
   logic [31:0] pc;
   logic        pc_valid;
   logic        fire;
   logic        addr_trans_ready;
   logic        redirect;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] data_bus;

   int ncmp = 0;
   int nerr = 0;
   int nfire;

   if_fetch_buffer #(.DEPTH(4), .CNT_W(3)) dut (
      .clk              (clk),
      .reset            (reset),
      .pc               (pc),
      .pc_valid         (pc_valid),
      .fire             (fire),
      .addr_trans_ready (addr_trans_ready),
      .redirect         (redirect),
      .inst_req         (inst_req),
      .inst_addr        (inst_addr),
      .inst_addr_ok     (inst_addr_ok),
      .inst_data_ok     (inst_data_ok),
      .inst_rdata       (inst_rdata),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .data_bus         (data_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      pc_valid     = 1'b0;
      inst_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      redirect     = 1'b0;
      inst_rdata   = 32'h0;
   endtask

   initial begin
      reset      = 1'b0;
      pc         = 32'h1C00_0000;
      out_ready  = 1'b0;
      idle();
      pc_valid     = 1'b1;
      inst_addr_ok = 1'b1;

      // reset state
      #3;
      chk("rst_fire",  fire, 1'b0);
      chk("rst_req",   inst_req, 1'b0);
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_atr",   addr_trans_ready, 1'b0);
      chk("rst_bus",   data_bus, 64'h0);
      cyc();
      cyc();
      reset = 1'b1;
      idle();

      // streaming
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cyc();
         pc           = 32'h1C00_0000 + 32'(4 * i);
         pc_valid     = (i < 8);
         inst_addr_ok = 1'b1;
         inst_data_ok = (i >= 1) && (i <= 8);
         inst_rdata   = 32'h0280_0000 + 32'(i - 1);
         #2;
         if (i < 8) chk($sformatf("stream_fire%0d", i), fire, 1'b1);
         if (i >= 2) begin
            chk($sformatf("stream_valid%0d", i), out_valid, 1'b1);
            chk($sformatf("stream_bus%0d", i), data_bus,
                {32'h1C00_0000 + 32'(4 * (i - 2)), 32'h0280_0000 + 32'(i - 2)});
         end else begin
            chk($sformatf("stream_valid%0d", i), out_valid, 1'b0);
         end
      end
      cyc();
      idle();
      #2;
      chk("stream_end", out_valid, 1'b0);

      // backpressure
      out_ready = 1'b0;
      nfire = 0;
      for (int i = 0; i < 6; i++) begin
         cyc();
         pc           = 32'h1C00_0200 + 32'(4 * nfire);
         pc_valid     = 1'b1;
         inst_addr_ok = 1'b1;
         inst_data_ok = (i >= 1) && (i <= 4);
         inst_rdata   = 32'h1111_0000 + 32'(i - 1);
         #2;
         chk($sformatf("bp_fire%0d", i), fire, (i < 4));
         if (i >= 4) chk($sformatf("bp_atr%0d", i), addr_trans_ready, 1'b0);
         if (fire) nfire++;
      end
      cyc();
      out_ready    = 1'b1;
      inst_data_ok = 1'b0;
      pc           = 32'h1C00_0200 + 32'(4 * nfire);
      #2;
      chk("bp_fire_full", fire, 1'b0);
      chk("bp_bus0", data_bus, {32'h1C00_0200, 32'h1111_0000});
      cyc();
      #2;
      chk("bp_fire_resume", fire, 1'b1);
      chk("bp_bus1", data_bus, {32'h1C00_0204, 32'h1111_0001});
      cyc();
      pc_valid     = 1'b0;
      inst_data_ok = 1'b1;
      inst_rdata   = 32'h1111_0004;
      #2;
      chk("bp_bus2", data_bus, {32'h1C00_0208, 32'h1111_0002});
      cyc();
      idle();
      #2;
      chk("bp_bus3", data_bus, {32'h1C00_020C, 32'h1111_0003});
      cyc();
      #2;
      chk("bp_bus4", data_bus, {32'h1C00_0210, 32'h1111_0004});
      cyc();
      #2;
      chk("bp_empty", out_valid, 1'b0);

      // redirect with 2 outstanding and 1 buffered
      out_ready = 1'b0;
      cyc();
      pc = 32'h1C00_0300; pc_valid = 1'b1; inst_addr_ok = 1'b1;
      cyc();
      pc = 32'h1C00_0304; inst_data_ok = 1'b1; inst_rdata = 32'hAAAA_0000;
      cyc();
      pc = 32'h1C00_0308; inst_data_ok = 1'b0;
      #2;
      chk("rd_fire3", fire, 1'b1);
      cyc();
      pc = 32'h1C00_030C; redirect = 1'b1;
      #2;
      chk("rd_req", inst_req, 1'b0);
      chk("rd_fire", fire, 1'b0);
      chk("rd_valid_pre", out_valid, 1'b1);
      chk("rd_bus_pre", data_bus, {32'h1C00_0300, 32'hAAAA_0000});
      cyc();
      redirect = 1'b0; pc = 32'h1C00_0100;
      inst_data_ok = 1'b1; inst_rdata = 32'hDEAD_0001;
      #2;
      chk("rd_valid_post", out_valid, 1'b0);
      chk("rd_fire_new", fire, 1'b1);
      cyc();
      pc_valid = 1'b0; inst_rdata = 32'hDEAD_0002;
      #2;
      chk("rd_drop1", out_valid, 1'b0);
      cyc();
      inst_rdata = 32'h0280_0100;
      #2;
      chk("rd_drop2", out_valid, 1'b0);
      cyc();
      idle();
      out_ready = 1'b1;
      #2;
      chk("rd_valid_new", out_valid, 1'b1);
      chk("rd_bus_new", data_bus, {32'h1C00_0100, 32'h0280_0100});
      cyc();
      #2;
      chk("rd_empty", out_valid, 1'b0);

      // redirect coinciding with data_ok and fire, 3 outstanding
      for (int i = 0; i < 3; i++) begin
         cyc();
         pc = 32'h1C00_0400 + 32'(4 * i); pc_valid = 1'b1; inst_addr_ok = 1'b1;
      end
      cyc();
      pc = 32'h1C00_040C; redirect = 1'b1;
      inst_data_ok = 1'b1; inst_rdata = 32'hBAD0_0000;
      #2;
      chk("rc_req", inst_req, 1'b0);
      chk("rc_fire", fire, 1'b0);
      cyc();
      redirect = 1'b0; pc = 32'h1C00_0500; inst_rdata = 32'hBAD0_0001;
      #2;
      chk("rc_valid_post", out_valid, 1'b0);
      chk("rc_fire_new", fire, 1'b1);
      cyc();
      pc_valid = 1'b0; inst_rdata = 32'hBAD0_0002;
      cyc();
      inst_rdata = 32'h0280_0500;
      #2;
      chk("rc_drop", out_valid, 1'b0);
      cyc();
      idle();
      #2;
      chk("rc_valid_new", out_valid, 1'b1);
      chk("rc_bus_new", data_bus, {32'h1C00_0500, 32'h0280_0500});
      cyc();
      #2;
      chk("rc_empty", out_valid, 1'b0);

      // async reset with 3 buffered
      out_ready = 1'b0;
      cyc();
      pc = 32'h1C00_0600; pc_valid = 1'b1; inst_addr_ok = 1'b1;
      cyc();
      pc = 32'h1C00_0604; inst_data_ok = 1'b1; inst_rdata = 32'h3333_0000;
      cyc();
      pc = 32'h1C00_0608; inst_rdata = 32'h3333_0001;
      cyc();
      pc_valid = 1'b0; inst_rdata = 32'h3333_0002;
      cyc();
      inst_data_ok = 1'b0;
      pc = 32'h1C00_060C; pc_valid = 1'b1;
      #2;
      chk("ar_valid_pre", out_valid, 1'b1);
      chk("ar_req_pre", inst_req, 1'b1);
      reset = 1'b0;
      #1;
      chk("ar_valid", out_valid, 1'b0);
      chk("ar_req", inst_req, 1'b0);
      chk("ar_fire", fire, 1'b0);
      cyc();
      reset = 1'b1;
      idle();
      #2;
      chk("ar_valid_rel", out_valid, 1'b0);
      chk("ar_bus_rel", data_bus, 64'h0);
      chk("ar_atr_rel", addr_trans_ready, 1'b1);
      cyc();
      pc = 32'h1C00_0700; pc_valid = 1'b1; inst_addr_ok = 1'b1;
      #2;
      chk("ar_fire_new", fire, 1'b1);
      cyc();
      pc_valid = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h0280_0700;
      cyc();
      idle();
      out_ready = 1'b1;
      #2;
      chk("ar_valid_new", out_valid, 1'b1);
      chk("ar_bus_new", data_bus, {32'h1C00_0700, 32'h0280_0700});
      cyc();

      // slow memory: addr_ok after 3 cycles
      nfire = 0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         pc           = 32'h1C00_0800;
         pc_valid     = (i < 4);
         inst_addr_ok = (i >= 3);
         #2;
         if (i < 4) begin
            chk($sformatf("sm_req%0d", i), inst_req, 1'b1);
            chk($sformatf("sm_addr%0d", i), inst_addr, 32'h1C00_0800);
         end
         if (fire) nfire++;
      end
      chk("sm_fire_count", 64'(nfire), 64'd1);
      cyc();
      idle();
      inst_data_ok = 1'b1;
      inst_rdata   = 32'h0280_0800;
      cyc();
      idle();
      #2;
      chk("sm_valid", out_valid, 1'b1);
      chk("sm_bus", data_bus, {32'h1C00_0800, 32'h0280_0800});
      cyc();
      #2;
      chk("sm_empty", out_valid, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
